// File: rtl/pwm_pkg.sv
// Shared defaults and channel-slicing helper for the multi-channel PWM block.
package pwm_pkg;

   localparam int DEF_WIDTH  = 10;
   localparam int DEF_NUM_CH = 2;

   // Bit offset of channel ch inside a packed duty bus of width-bit lanes.
   function automatic int unsigned duty_lsb(input int unsigned ch, input int unsigned width);
      return ch * width;
   endfunction

endpackage

// File: rtl/pwm_channel.sv
// One PWM channel: double-buffered duty, registered compare, brake override, polarity.
module pwm_channel
   import pwm_pkg::*;
#(
   parameter int   WIDTH     = DEF_WIDTH,
   parameter logic POL       = 1'b0,
   parameter logic BRAKE_LVL = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] cnt,
   input  logic             en,
   input  logic             apply,
   input  logic             load,
   input  logic             load_pending,
   input  logic [WIDTH-1:0] duty_in,
   input  logic             brake,
   output logic             pwm_out
);

   logic [WIDTH-1:0] shadow;
   logic [WIDTH-1:0] duty_act;
   logic             level;

   // A load that lands on an apply cycle bypasses the shadow entirely.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shadow   <= '0;
         duty_act <= '0;
      end else if (apply) begin
         if (load)
            duty_act <= duty_in;
         else if (load_pending)
            duty_act <= shadow;
      end else if (load) begin
         shadow <= duty_in;
      end
   end

   assign level = en && (cnt < duty_act);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         pwm_out <= POL;
      else if (brake)
         pwm_out <= BRAKE_LVL ^ POL;
      else
         pwm_out <= level ^ POL;
   end

endmodule

// File: rtl/pwm_multi_channel.sv
// Multi-channel PWM: shared period counter, boundary/enable handling, period-start sync pulse.
module pwm_multi_channel
   import pwm_pkg::*;
#(
   parameter int                WIDTH       = DEF_WIDTH,
   parameter int                NUM_CH      = DEF_NUM_CH,
   parameter logic [NUM_CH-1:0] POL_MASK    = '0,
   parameter logic [NUM_CH-1:0] BRAKE_LEVEL = '1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    en,
   input  logic [WIDTH-1:0]        period,
   input  logic [NUM_CH*WIDTH-1:0] duty_in,
   input  logic                    load,
   input  logic                    brake,
   output logic [NUM_CH-1:0]       pwm_out,
   output logic                    period_start,
   output logic                    load_pending
);

   logic [WIDTH-1:0] cnt;
   logic [WIDTH-1:0] period_act;
   logic             at_end;
   logic             apply;

   // While disabled every cycle behaves like a boundary for period and duty updates.
   assign at_end = (cnt == period_act);
   assign apply  = !en || at_end;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt          <= '0;
         period_act   <= '0;
         load_pending <= 1'b0;
         period_start <= 1'b0;
      end else begin
         if (!en || at_end)
            cnt <= '0;
         else
            cnt <= cnt + 1'b1;
         if (apply)
            period_act <= period;
         if (apply)
            load_pending <= 1'b0;
         else if (load)
            load_pending <= 1'b1;
         period_start <= en && (cnt == '0);
      end
   end

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      pwm_channel #(
         .WIDTH     (WIDTH),
         .POL       (POL_MASK[i]),
         .BRAKE_LVL (BRAKE_LEVEL[i])
      ) u_ch (
         .clk          (clk),
         .rst_n        (rst_n),
         .cnt          (cnt),
         .en           (en),
         .apply        (apply),
         .load         (load),
         .load_pending (load_pending),
         .duty_in      (duty_in[duty_lsb(i, WIDTH) +: WIDTH]),
         .brake        (brake),
         .pwm_out      (pwm_out[i])
      );
   end

endmodule

// File: tb/tb_pwm_multi_channel.sv
// Self-checking bench for pwm_multi_channel: directed scenarios plus randomized traffic vs. a cycle model.
module tb_pwm_multi_channel;

   localparam int         W   = 10;
   localparam int         NCH = 2;
   localparam logic [1:0] POL = 2'b10;
   localparam logic [1:0] BRK = 2'b11;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic           en = 1'b0;
   logic           load = 1'b0;
   logic           brake = 1'b0;
   logic [W-1:0]   period = '0;
   logic [2*W-1:0] duty_in = '0;
   logic [1:0]     pwm_out;
   logic           period_start;
   logic           load_pending;

   pwm_multi_channel #(
      .WIDTH       (W),
      .NUM_CH      (NCH),
      .POL_MASK    (POL),
      .BRAKE_LEVEL (BRK)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .en           (en),
      .period       (period),
      .duty_in      (duty_in),
      .load         (load),
      .brake        (brake),
      .pwm_out      (pwm_out),
      .period_start (period_start),
      .load_pending (load_pending)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   int total = 0;
   int bad   = 0;

   // Reference state: {load_pending, period_start, pwm_out} expected after each edge.
   int         m_cnt, m_pact, m_pend;
   int         m_duty[NCH];
   int         m_shadow[NCH];
   logic [3:0] exp_q[$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic int duty_of(input int ch);
      return int'(duty_in[ch*W +: W]);
   endfunction

   task automatic model_reset();
      m_cnt  = 0;
      m_pact = 0;
      m_pend = 0;
      for (int c = 0; c < NCH; c++) begin
         m_duty[c]   = 0;
         m_shadow[c] = 0;
      end
      exp_q.delete();
   endtask

   task automatic model_step();
      logic [1:0] o;
      logic       ps;
      bit         apply;
      apply = !en || (m_cnt == m_pact);
      for (int c = 0; c < NCH; c++)
         o[c] = brake ? (BRK[c] ^ POL[c]) : ((en && (m_cnt < m_duty[c])) ^ POL[c]);
      ps = en && (m_cnt == 0);
      for (int c = 0; c < NCH; c++) begin
         if (apply) begin
            if (load) m_duty[c] = duty_of(c);
            else if (m_pend != 0) m_duty[c] = m_shadow[c];
         end else if (load) begin
            m_shadow[c] = duty_of(c);
         end
      end
      if (apply) m_pend = 0;
      else if (load) m_pend = 1;
      m_cnt  = !en ? 0 : ((m_cnt == m_pact) ? 0 : m_cnt + 1);
      if (apply) m_pact = int'(period);
      exp_q.push_back({m_pend[0], ps, o});
   endtask

   task automatic tick();
      logic [3:0] e;
      @(posedge clk);
      model_step();
      #1;
      e = exp_q.pop_front();
      check("pwm_out", 32'(pwm_out), 32'(e[1:0]));
      check("period_start", 32'(period_start), 32'(e[2]));
      check("load_pending", 32'(load_pending), 32'(e[3]));
   endtask

   task automatic load_duties(input int d0, input int d1);
      duty_in = {W'(d1), W'(d0)};
      load = 1'b1;
      tick();
      load = 1'b0;
   endtask

   task automatic wait_cnt(input int c);
      for (int i = 0; i < 64 && m_cnt != c; i++) tick();
      check("wait_cnt", 32'(m_cnt), 32'(c));
   endtask

   // Count logical high cycles per channel across one whole period, from its period_start.
   task automatic measure(input int len, input int exp0, input int exp1);
      int n, hi0, hi1;
      n = 0;
      while (!period_start && n < 64) begin
         tick();
         n++;
      end
      check("period_start_seen", 32'(period_start), 32'd1);
      hi0 = int'(pwm_out[0] ^ POL[0]);
      hi1 = int'(pwm_out[1] ^ POL[1]);
      for (int k = 1; k < len; k++) begin
         tick();
         hi0 += int'(pwm_out[0] ^ POL[0]);
         hi1 += int'(pwm_out[1] ^ POL[1]);
      end
      check("high_ch0", 32'(hi0), 32'(exp0));
      check("high_ch1", 32'(hi1), 32'(exp1));
   endtask

   initial begin
      model_reset();
      #12;
      check("rst_pwm_out", 32'(pwm_out), 32'(POL));
      check("rst_period_start", 32'(period_start), 32'd0);
      check("rst_load_pending", 32'(load_pending), 32'd0);
      rst_n = 1'b1;

      // Period 10, ch0 = 3, ch1 = 10 (full on).
      en = 1'b1;
      period = W'(9);
      load_duties(3, 10);
      repeat (3) tick();
      measure(10, 3, 10);
      measure(10, 3, 10);

      // Mid-period load: current period keeps 3, next shows 7.
      wait_cnt(4);
      load_duties(7, 10);
      check("mid_load_pending", 32'(load_pending), 32'd1);
      measure(10, 7, 10);

      // Load exactly on the terminal count: never pending, takes effect next period.
      wait_cnt(9);
      load_duties(5, 2);
      check("edge_load_pending", 32'(load_pending), 32'd0);
      measure(10, 5, 2);

      // Period 0: every cycle a boundary.
      period = '0;
      load_duties(0, 0);
      repeat (15) tick();
      for (int k = 0; k < 4; k++) begin
         tick();
         check("p0_low", 32'(pwm_out), 32'(POL));
         check("p0_ps", 32'(period_start), 32'd1);
      end
      load_duties(1, 1);
      repeat (2) tick();
      for (int k = 0; k < 3; k++) begin
         tick();
         check("p0_high", 32'(pwm_out), 32'(2'b11 ^ POL));
      end

      // Brake mid-period.
      period = W'(9);
      load_duties(3, 6);
      repeat (20) tick();
      wait_cnt(2);
      brake = 1'b1;
      for (int k = 0; k < 5; k++) begin
         tick();
         check("brake_out", 32'(pwm_out), 32'(2'b01));
      end
      brake = 1'b0;
      repeat (3) tick();
      measure(10, 3, 6);

      // Async reset mid-period with a pending load.
      wait_cnt(3);
      load_duties(8, 8);
      tick();
      rst_n = 1'b0;
      #1;
      check("arst_pwm_out", 32'(pwm_out), 32'(POL));
      check("arst_period_start", 32'(period_start), 32'd0);
      check("arst_load_pending", 32'(load_pending), 32'd0);
      model_reset();
      #2;
      rst_n = 1'b1;
      repeat (25) tick();
      check("post_rst_idle", 32'(pwm_out), 32'(POL));

      // Disable, reprogram while idle, then re-enable.
      en = 1'b0;
      period = W'(4);
      load_duties(2, 4);
      for (int k = 0; k < 4; k++) begin
         tick();
         check("dis_out", 32'(pwm_out), 32'(POL));
         check("dis_ps", 32'(period_start), 32'd0);
      end
      en = 1'b1;
      tick();
      check("reen_ps", 32'(period_start), 32'd1);
      measure(5, 2, 4);

      // Randomized traffic against the model.
      for (int i = 0; i < 600; i++) begin
         en    = ($urandom_range(0, 9) != 0);
         load  = ($urandom_range(0, 7) == 0);
         brake = ($urandom_range(0, 19) == 0);
         if ($urandom_range(0, 15) == 0) period = W'($urandom_range(0, 12));
         duty_in = {W'($urandom_range(0, 14)), W'($urandom_range(0, 14))};
         tick();
      end
      load  = 1'b0;
      brake = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
